// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants: operand width, FS codes, MDU state encoding
package mips_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] FS_MUL = 5'h1E;
  localparam logic [4:0] FS_DIV = 5'h1F;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_SIGN,
    MDU_DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational MDU iteration: shift-add multiply or restoring divide step
// Divider path present only when MIPS_MDU_DIV_EN is defined.
module mdu_step
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
`ifdef MIPS_MDU_DIV_EN
  input  logic               op_div_i,
  input  logic [WIDTH:0]     rem_i,
  output logic [WIDTH:0]     rem_o,
  output logic               qbit_o,
`endif
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;

  // Upper half accumulates the product; lower half holds the unconsumed multiplier bits.
  always_comb begin
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    mul_acc = {mul_sum, acc_i[WIDTH-1:1]};
  end

`ifdef MIPS_MDU_DIV_EN
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] div_acc;

  // Lower word shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    diff    = {rem_i, acc_i[WIDTH-1]} - {2'b00, operand_i};
    qbit_o  = ~diff[WIDTH+1];
    rem_o   = qbit_o ? diff[WIDTH:0] : {rem_i[WIDTH-1:0], acc_i[WIDTH-1]};
    div_acc = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], 1'b0};
    acc_o   = op_div_i ? div_acc : mul_acc;
  end
`else
  assign acc_o = mul_acc;
`endif

endmodule

// File: rtl/mips_mdu.sv
// rtl/mips_mdu.sv - sequential signed multiply/divide unit writing HI/LO over 33 cycles
// Define MIPS_MDU_DIV_EN to build the divider; otherwise DIV is rejected like divide-by-zero.
module mips_mdu
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_state_e         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_quo_q, neg_quo_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH-1:0]   abs_s, abs_t;
  logic [2*WIDTH-1:0] step_acc;

`ifdef MIPS_MDU_DIV_EN
  logic [WIDTH:0]     rem_q, rem_d, step_rem;
  logic               op_div_q, op_div_d, neg_rem_q, neg_rem_d;
  logic               step_qbit;
`endif

  assign abs_s = S[WIDTH-1] ? -S : S;
  assign abs_t = T[WIDTH-1] ? -T : T;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
`ifdef MIPS_MDU_DIV_EN
    .op_div_i  (op_div_q),
    .rem_i     (rem_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit),
`endif
    .acc_o     (step_acc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_quo_d = neg_quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
`ifdef MIPS_MDU_DIV_EN
    rem_d     = rem_q;
    op_div_d  = op_div_q;
    neg_rem_d = neg_rem_q;
`endif

    case (state_q)
      MDU_IDLE: begin
        if (start && FS == FS_MUL) begin
          state_d   = MDU_CALC;
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, abs_t};
          opnd_d    = abs_s;
          neg_quo_d = S[WIDTH-1] ^ T[WIDTH-1];
`ifdef MIPS_MDU_DIV_EN
          op_div_d  = 1'b0;
`endif
        end else if (start && FS == FS_DIV) begin
`ifdef MIPS_MDU_DIV_EN
          if (T == '0) begin
            state_d = MDU_DONE;
          end else begin
            state_d   = MDU_CALC;
            cnt_d     = '0;
            acc_d     = {{WIDTH{1'b0}}, abs_s};
            opnd_d    = abs_t;
            rem_d     = '0;
            neg_quo_d = S[WIDTH-1] ^ T[WIDTH-1];
            neg_rem_d = S[WIDTH-1];
            op_div_d  = 1'b1;
          end
`else
          state_d = MDU_DONE;
`endif
        end
      end

      MDU_CALC: begin
        acc_d = step_acc;
`ifdef MIPS_MDU_DIV_EN
        if (op_div_q) begin
          acc_d = {step_acc[2*WIDTH-1:1], step_qbit};
          rem_d = step_rem;
        end
`endif
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = MDU_SIGN;
        end
      end

      MDU_SIGN: begin
        {hi_d, lo_d} = neg_quo_q ? -acc_q : acc_q;
`ifdef MIPS_MDU_DIV_EN
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        if (op_div_q) begin
          lo_d = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
`endif
        done_d  = 1'b1;
        state_d = MDU_IDLE;
      end

      MDU_DONE: begin
        done_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = MDU_IDLE;
      end

      default: state_d = MDU_IDLE;
    endcase

    busy_d = (state_d == MDU_CALC) || (state_d == MDU_SIGN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_quo_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
`ifdef MIPS_MDU_DIV_EN
      rem_q     <= '0;
      op_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_quo_q <= neg_quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
`ifdef MIPS_MDU_DIV_EN
      rem_q     <= rem_d;
      op_div_q  <= op_div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// tb/tb_mips_mdu.sv - directed self-checking bench for mips_mdu (DIV expectations follow MIPS_MDU_DIV_EN)
module tb_mips_mdu;
  import mips_pkg::*;

`ifdef MIPS_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  fs;
  logic [31:0] s, t;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_hi, exp_lo;
  int          cyc, nbusy;

  always #5 clk = ~clk;

  mips_mdu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .FS    (fs),
    .S     (s),
    .T     (t),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .HI    (hi),
    .LO    (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Operands are scrambled after E so a late re-sample would show up in the result.
  task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    fs    = f;
    s     = a;
    t     = b;
    step();
    start = 1'b0;
    fs    = 5'h00;
    s     = $urandom;
    t     = $urandom;
  endtask

  task automatic wait_done(output int c, output int nb);
    c  = -1;
    nb = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (busy) nb++;
      if (done) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic watch_idle(input string tag, input int n);
    int nd, nb;
    nd = 0;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done) nd++;
      if (busy) nb++;
    end
    check({tag, " done count"}, nd, 0);
    check({tag, " busy count"}, nb, 0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic exp_dz,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int c, nb;
    issue(f, a, b);
    check({tag, " busy after E"}, busy, (exp_lat == 33) ? 1'b1 : 1'b0);
    wait_done(c, nb);
    check({tag, " latency"}, c, exp_lat);
    check({tag, " busy cycles"}, nb, (exp_lat == 33) ? 32 : 0);
    check({tag, " busy at done"}, busy, 1'b0);
    check({tag, " dz"}, dz, exp_dz);
    check({tag, " HI"}, hi, ehi);
    check({tag, " LO"}, lo, elo);
  endtask

  task automatic check_pulse_end(input string tag);
    step();
    check({tag, " done clear"}, done, 1'b0);
    check({tag, " dz clear"}, dz, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fs    = 5'h00;
    s     = '0;
    t     = '0;
    repeat (3) step();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset dz", dz, 1'b0);
    check("reset HI", hi, 32'h0);
    check("reset LO", lo, 32'h0);
    reset = 1'b0;
    step();

    run_op("mul 7x-3", FS_MUL, 32'd7, 32'hFFFF_FFFD, 33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    check_pulse_end("mul 7x-3");

    issue(5'h02, 32'd1, 32'd2);
    watch_idle("add ignored", 40);
    check("add HI", hi, 32'hFFFF_FFFF);
    check("add LO", lo, 32'hFFFF_FFEB);

    run_op("mul max", FS_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001);
    exp_hi = DIV_EN ? 32'hFFFF_FFFF : 32'h3FFF_FFFF;
    exp_lo = DIV_EN ? 32'hFFFF_FFFD : 32'h0000_0001;
    run_op("b2b div -7/2", FS_DIV, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 33 : 1, ~DIV_EN, exp_hi, exp_lo);
    check_pulse_end("b2b div -7/2");

    exp_hi = DIV_EN ? 32'h0000_0001 : exp_hi;
    exp_lo = DIV_EN ? 32'hFFFF_FFFD : exp_lo;
    run_op("div 7/-2", FS_DIV, 32'd7, 32'hFFFF_FFFE, DIV_EN ? 33 : 1, ~DIV_EN, exp_hi, exp_lo);

    exp_hi = DIV_EN ? 32'h0000_0000 : exp_hi;
    exp_lo = DIV_EN ? 32'h8000_0000 : exp_lo;
    run_op("div wrap", FS_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 33 : 1, ~DIV_EN, exp_hi, exp_lo);

    run_op("mul preload", FS_MUL, 32'h3333_3333, 32'h5555_5556, 33, 1'b0, 32'h1111_1111, 32'h2222_2222);
    run_op("div by zero", FS_DIV, 32'd5, 32'd0, 1, 1'b1, 32'h1111_1111, 32'h2222_2222);
    check_pulse_end("div by zero");

    // Extra starts while busy must neither restart nor queue an operation.
    issue(FS_MUL, 32'd5, 32'd6);
    repeat (4) step();
    start = 1'b1;
    fs    = FS_MUL;
    s     = 32'd100;
    t     = 32'd100;
    step();
    fs    = FS_DIV;
    t     = 32'd0;
    step();
    start = 1'b0;
    check("busy-start busy", busy, 1'b1);
    wait_done(cyc, nbusy);
    check("busy-start latency", cyc, 27);
    check("busy-start dz", dz, 1'b0);
    check("busy-start HI", hi, 32'd0);
    check("busy-start LO", lo, 32'd30);
    watch_idle("busy-start after", 40);

    issue(FS_MUL, 32'd9, 32'd9);
    repeat (9) step();
    reset = 1'b1;
    #1;
    check("mid reset HI", hi, 32'h0);
    check("mid reset LO", lo, 32'h0);
    check("mid reset busy", busy, 1'b0);
    check("mid reset done", done, 1'b0);
    step();
    reset = 1'b0;
    step();
    check("post reset busy", busy, 1'b0);
    run_op("mul 3x4", FS_MUL, 32'd3, 32'd4, 33, 1'b0, 32'h0, 32'd12);
    check_pulse_end("mul 3x4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
